// File: rtl/spi_lvds_tx_top_if.sv
// Host SPI pin bundle for the SPI register block / LVDS transmit front end.
// The host drives SCLK, SSB and MOSI. The slave drives MISO.
interface spi_lvds_tx_top_if;
   logic sclk;
   logic ssb;
   logic mosi;
   logic miso;

   modport master (
      output sclk,
      output ssb,
      output mosi,
      input  miso
   );

   modport slave (
      input  sclk,
      input  ssb,
      input  mosi,
      output miso
   );
endinterface

// File: rtl/spi_lvds_tx_top.sv
// SPI-controlled register block with an LVDS dibit transmit sequencer.
// The SPI pins are oversampled in the clk domain and feed a 16-bit frame decoder.
// The decoder drives an eight-entry register file.
// A two-state FSM serialises TX_PACKET onto to_lvds_o while TX_EN is set.
module spi_lvds_tx_top #(
   parameter int PKTSZ   = 16,
   parameter int HEADER  = 8,
   parameter int PAYLOAD = 8,
   parameter int ADDRSZ  = 7
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   spi_lvds_tx_top_if.slave       spi,
   output logic [7:0]             gpo_o,
   output logic [7:0]             led_o,
   output logic [1:0]             to_lvds_o
);

   localparam int CNTW = $clog2(PKTSZ + 1);
   localparam logic [CNTW-1:0] CNT_HDR  = CNTW'(HEADER - 1);
   localparam logic [CNTW-1:0] CNT_DAT  = CNTW'(HEADER);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(PKTSZ - 1);
   localparam logic [CNTW-1:0] CNT_END  = CNTW'(PKTSZ);

   typedef enum logic [0:0] {
      TX_IDLE = 1'b0,
      TX_SEND = 1'b1
   } tx_state_e;

   // Synchronizers and edge detection
   logic [1:0] sclk_sync_q;
   logic [1:0] ssb_sync_q;
   logic [1:0] mosi_sync_q;
   logic       sclk_prev_q;
   logic       sclk_s;
   logic       ssb_s;
   logic       mosi_s;
   logic       sclk_rise_s;

   // Two-flop synchronizers on the SPI pins, plus the previous SCLK sample for edge detection
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sclk_sync_q <= 2'b00;
         ssb_sync_q  <= 2'b11;
         mosi_sync_q <= 2'b00;
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], spi.sclk};
         ssb_sync_q  <= {ssb_sync_q[0], spi.ssb};
         mosi_sync_q <= {mosi_sync_q[0], spi.mosi};
         sclk_prev_q <= sclk_sync_q[1];
      end
   end

   assign sclk_s      = sclk_sync_q[1];
   assign ssb_s       = ssb_sync_q[1];
   assign mosi_s      = mosi_sync_q[1];
   assign sclk_rise_s = sclk_s & ~sclk_prev_q;

   // Frame decoder
   logic [CNTW-1:0]    bit_cnt_q;
   logic [PAYLOAD-2:0] rx_shift_q;
   logic [PAYLOAD-1:0] shift_in_s;
   logic [ADDRSZ-1:0]  addr_q;
   logic               rw_q;
   logic               rxdv_q;
   logic [7:0]         rx_d_q;
   logic [7:0]         miso_shift_q;
   logic               miso_q;
   logic [7:0]         rd_data_s;

   // Only the most recent byte is kept. The header is consumed at bit 8 and the data byte at bit 16.
   assign shift_in_s = {rx_shift_q, mosi_s};

   // Register file storage
   logic [7:0] gpo_q;
   logic [7:0] led_q;
   logic [7:0] dac_q;
   logic [7:0] tx_len_q;
   logic [7:0] tx_pkt_q;
   logic [7:0] rx_len_q;
   logic [7:0] rx_pkt_q;
   logic       tx_en_s;
   logic       busy_s;

   assign tx_en_s = dac_q[0];

   // Read mux, addressed by the header currently being completed on the 8th rising edge
   always_comb begin
      rd_data_s = 8'h00;
      case (shift_in_s[HEADER-1:1])
         7'h20:   rd_data_s = gpo_q;
         7'h21:   rd_data_s = led_q;
         7'h22:   rd_data_s = {6'b000000, busy_s, tx_en_s};
         7'h23:   rd_data_s = dac_q;
         7'h24:   rd_data_s = tx_len_q;
         7'h25:   rd_data_s = tx_pkt_q;
         7'h26:   rd_data_s = rx_len_q;
         7'h27:   rd_data_s = rx_pkt_q;
         default: rd_data_s = 8'h00;
      endcase
   end

   // SPI bit counter, header latch, MISO shifter and write strobe generation
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         bit_cnt_q    <= '0;
         rx_shift_q   <= '0;
         addr_q       <= '0;
         rw_q         <= 1'b0;
         rxdv_q       <= 1'b0;
         rx_d_q       <= 8'h00;
         miso_shift_q <= 8'h00;
         miso_q       <= 1'b0;
      end else begin
         rxdv_q <= 1'b0;
         if (ssb_s) begin
            // Deselected: drop any partial frame and wait for the next SSB falling edge
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
         end else if (sclk_rise_s && (bit_cnt_q != CNT_END)) begin
            rx_shift_q <= shift_in_s[PAYLOAD-2:0];
            bit_cnt_q  <= bit_cnt_q + CNTW'(1);
            if (bit_cnt_q == CNT_HDR) begin
               addr_q       <= shift_in_s[HEADER-1:1];
               rw_q         <= shift_in_s[0];
               miso_shift_q <= shift_in_s[0] ? rd_data_s : 8'h00;
               miso_q       <= shift_in_s[0] ? rd_data_s[7] : 1'b0;
            end else if ((bit_cnt_q >= CNT_DAT) && (bit_cnt_q < CNT_LAST)) begin
               miso_q       <= miso_shift_q[6];
               miso_shift_q <= {miso_shift_q[6:0], 1'b0};
            end else begin
               miso_q <= miso_q;
            end
            if ((bit_cnt_q == CNT_LAST) && !rw_q) begin
               rxdv_q <= 1'b1;
               rx_d_q <= shift_in_s;
            end else begin
               rxdv_q <= 1'b0;
            end
         end else begin
            bit_cnt_q <= bit_cnt_q;
         end
      end
   end

   assign spi.miso = miso_q;

   // Register file write port. STATUS and unmapped addresses ignore writes.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         gpo_q    <= 8'h00;
         led_q    <= 8'h00;
         dac_q    <= 8'h00;
         tx_len_q <= 8'h00;
         tx_pkt_q <= 8'h00;
         rx_len_q <= 8'h00;
         rx_pkt_q <= 8'h00;
      end else if (rxdv_q) begin
         case (addr_q)
            7'h20:   gpo_q    <= rx_d_q;
            7'h21:   led_q    <= rx_d_q;
            7'h23:   dac_q    <= rx_d_q;
            7'h24:   tx_len_q <= rx_d_q;
            7'h25:   tx_pkt_q <= rx_d_q;
            7'h26:   rx_len_q <= rx_d_q;
            7'h27:   rx_pkt_q <= rx_d_q;
            default: gpo_q    <= gpo_q;
         endcase
      end else begin
         gpo_q <= gpo_q;
      end
   end

   assign gpo_o = gpo_q;
   assign led_o = led_q;

   // Transmit sequencer
   tx_state_e  state_q, state_d;
   logic [1:0] dib_cnt_q, dib_cnt_d;
   logic [7:0] byte_q, byte_d;
   logic [1:0] lvds_q, lvds_d;

   function automatic logic [1:0] dibit_sel(input logic [7:0] b, input logic [1:0] idx);
      logic [1:0] r;
      case (idx)
         2'd0:    r = b[7:6];
         2'd1:    r = b[5:4];
         2'd2:    r = b[3:2];
         2'd3:    r = b[1:0];
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   assign busy_s = (state_q == TX_SEND);

   // Transmit state, dibit index, latched byte and registered LVDS output
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= TX_IDLE;
         dib_cnt_q <= 2'd0;
         byte_q    <= 8'h00;
         lvds_q    <= 2'b00;
      end else begin
         state_q   <= state_d;
         dib_cnt_q <= dib_cnt_d;
         byte_q    <= byte_d;
         lvds_q    <= lvds_d;
      end
   end

   // Next state. While in SEND, lvds_q holds dibit dib_cnt_q of byte_q.
   always_comb begin
      state_d   = state_q;
      dib_cnt_d = dib_cnt_q;
      byte_d    = byte_q;
      lvds_d    = 2'b00;
      case (state_q)
         TX_IDLE: begin
            if (tx_en_s) begin
               state_d   = TX_SEND;
               byte_d    = tx_pkt_q;
               dib_cnt_d = 2'd0;
               lvds_d    = tx_pkt_q[7:6];
            end else begin
               dib_cnt_d = 2'd0;
               lvds_d    = 2'b00;
            end
         end
         TX_SEND: begin
            if (dib_cnt_q != 2'd3) begin
               dib_cnt_d = dib_cnt_q + 2'd1;
               lvds_d    = dibit_sel(byte_q, dib_cnt_q + 2'd1);
            end else if (tx_en_s) begin
               byte_d    = tx_pkt_q;
               dib_cnt_d = 2'd0;
               lvds_d    = tx_pkt_q[7:6];
            end else begin
               state_d   = TX_IDLE;
               dib_cnt_d = 2'd0;
               lvds_d    = 2'b00;
            end
         end
         default: begin
            state_d   = TX_IDLE;
            dib_cnt_d = 2'd0;
            lvds_d    = 2'b00;
         end
      endcase
   end

   assign to_lvds_o = lvds_q;

endmodule

// File: tb/tb_spi_lvds_tx_top.sv
// Self-checking bench for spi_lvds_tx_top: table vectors, hand-written TX and abort
// sequences, and randomized register traffic checked against a register-map model.
module tb_spi_lvds_tx_top;

   localparam int HALF = 40;   // SCLK half period in ns; clk period is 10 ns

   logic       clk;
   logic       rst_n;
   logic [7:0] gpo;
   logic [7:0] led;
   logic [1:0] to_lvds;

   spi_lvds_tx_top_if spi_bus ();

   spi_lvds_tx_top dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .spi       (spi_bus.slave),
      .gpo_o     (gpo),
      .led_o     (led),
      .to_lvds_o (to_lvds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Register-map reference model, indexed by address - 0x20
   logic [7:0] m_reg [0:7];

   logic [1:0] mon_q [$];
   bit         mon_en = 1'b0;

   always @(negedge clk) begin
      if (mon_en) mon_q.push_back(to_lvds);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic in_map(input logic [6:0] a);
      return (a >= 7'h20) && (a <= 7'h27);
   endfunction

   function automatic logic [7:0] m_read(input logic [6:0] a);
      logic en;
      if (!in_map(a)) return 8'h00;
      en = m_reg[3][0];
      if (a == 7'h22) return {6'b000000, en, en};
      return m_reg[a[2:0]];
   endfunction

   task automatic m_apply(input logic [15:0] f);
      logic [6:0] a;
      a = f[15:9];
      if (!f[8] && in_map(a) && (a != 7'h22)) m_reg[a[2:0]] = f[7:0];
   endtask

   task automatic m_reset();
      for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
   endtask

   // Host-side SPI transfer. nbits of the frame are sent, then nextra extra SCLK pulses.
   task automatic xfer(input logic [15:0] f, input int nbits, input int nextra, output logic [7:0] rd);
      rd = 8'h00;
      spi_bus.ssb = 1'b0;
      #80;
      for (int k = 0; k < nbits + nextra; k++) begin
         spi_bus.mosi = (k < 16) ? f[15-k] : 1'b1;
         #HALF;
         if (k >= 8 && k < 16) rd = {rd[6:0], spi_bus.miso};
         spi_bus.sclk = 1'b1;
         #HALF;
         spi_bus.sclk = 1'b0;
      end
      #HALF;
      spi_bus.ssb  = 1'b1;
      spi_bus.mosi = 1'b0;
      #120;
   endtask

   // Full frame checked against the model: read data, then gpo/led after the model update
   task automatic do_frame(input string nm, input logic [15:0] f);
      logic [7:0] rd;
      logic [7:0] exp_rd;
      exp_rd = m_read(f[15:9]);
      xfer(f, 16, 0, rd);
      if (f[8]) chk({nm, "_rd"}, {24'h0, rd}, {24'h0, exp_rd});
      m_apply(f);
      chk({nm, "_gpo"}, {24'h0, gpo}, {24'h0, m_reg[0]});
      chk({nm, "_led"}, {24'h0, led}, {24'h0, m_reg[1]});
   endtask

   typedef struct {
      logic [15:0] frame;
      logic [7:0]  exp_rd;
      logic [7:0]  exp_gpo;
      logic [7:0]  exp_led;
   } vec_t;

   vec_t tbl [15];

   initial begin
      logic [7:0]  rd;
      logic [1:0]  smp [12];
      logic [7:0]  pkt;
      logic        found;
      logic        ok;
      int          li;
      logic [6:0]  ra;
      logic [7:0]  rdat;

      tbl[0]  = '{16'h405A, 8'h00, 8'h5A, 8'h00};
      tbl[1]  = '{16'h4100, 8'h5A, 8'h5A, 8'h00};
      tbl[2]  = '{16'h423C, 8'h00, 8'h5A, 8'h3C};
      tbl[3]  = '{16'h4300, 8'h3C, 8'h5A, 8'h3C};
      tbl[4]  = '{16'h20AA, 8'h00, 8'h5A, 8'h3C};
      tbl[5]  = '{16'h2100, 8'h00, 8'h5A, 8'h3C};
      tbl[6]  = '{16'h44FF, 8'h00, 8'h5A, 8'h3C};
      tbl[7]  = '{16'h4500, 8'h00, 8'h5A, 8'h3C};
      tbl[8]  = '{16'h4811, 8'h00, 8'h5A, 8'h3C};
      tbl[9]  = '{16'h4900, 8'h11, 8'h5A, 8'h3C};
      tbl[10] = '{16'h4E77, 8'h00, 8'h5A, 8'h3C};
      tbl[11] = '{16'h4F00, 8'h77, 8'h5A, 8'h3C};
      tbl[12] = '{16'h46FE, 8'h00, 8'h5A, 8'h3C};
      tbl[13] = '{16'h4700, 8'hFE, 8'h5A, 8'h3C};
      tbl[14] = '{16'h4600, 8'h00, 8'h5A, 8'h3C};

      spi_bus.sclk = 1'b0;
      spi_bus.ssb  = 1'b1;
      spi_bus.mosi = 1'b0;
      rst_n        = 1'b0;
      m_reset();

      // Reset state
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_lvds", {30'h0, to_lvds}, 32'h0);
      chk("rst_gpo", {24'h0, gpo}, 32'h0);
      chk("rst_led", {24'h0, led}, 32'h0);
      chk("rst_miso", {31'h0, spi_bus.miso}, 32'h0);
      xfer(16'h4500, 16, 0, rd);
      chk("rst_status", {24'h0, rd}, 32'h0);
      chk("rst_lvds2", {30'h0, to_lvds}, 32'h0);

      // Table-driven register accesses
      for (int i = 0; i < 15; i++) begin
         xfer(tbl[i].frame, 16, 0, rd);
         m_apply(tbl[i].frame);
         if (tbl[i].frame[8]) chk($sformatf("tbl%0d_rd", i), {24'h0, rd}, {24'h0, tbl[i].exp_rd});
         chk($sformatf("tbl%0d_gpo", i), {24'h0, gpo}, {24'h0, tbl[i].exp_gpo});
         chk($sformatf("tbl%0d_led", i), {24'h0, led}, {24'h0, tbl[i].exp_led});
      end

      // Aborted write after 10 bits leaves GPO unchanged
      xfer(16'h4055, 10, 0, rd);
      chk("abort_gpo", {24'h0, gpo}, 32'h5A);
      do_frame("after_abort_rd", 16'h4100);
      // Extra SCLK pulses after bit 16 are ignored
      xfer(16'h400F, 16, 3, rd);
      m_apply(16'h400F);
      chk("extra_gpo", {24'h0, gpo}, 32'h0F);
      do_frame("extra_rd", 16'h4100);

      // Transmit: TX_PACKET = 0xB4, then TX_EN = 1
      do_frame("tx_pkt", 16'h4AB4);
      do_frame("tx_en", 16'h4601);
      #100;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         smp[k] = to_lvds;
      end
      pkt   = 8'hB4;
      found = 1'b0;
      for (int p = 0; p < 4; p++) begin
         ok = 1'b1;
         for (int k = 0; k < 12; k++) begin
            if (smp[k] !== pkt[7 - 2*((k+p)%4) -: 2]) ok = 1'b0;
         end
         if (ok) found = 1'b1;
      end
      chk("tx_pattern", {31'h0, found}, 32'h1);
      do_frame("tx_status", 16'h4500);

      // Clear TX_EN while sending: the byte in flight completes, then the output idles
      mon_q.delete();
      mon_en = 1'b1;
      xfer(16'h4600, 16, 0, rd);
      m_apply(16'h4600);
      #300;
      mon_en = 1'b0;
      li = -1;
      for (int k = 0; k < mon_q.size(); k++) begin
         if (mon_q[k] != 2'b00) li = k;
      end
      chk("stop_seen", {31'h0, (li >= 1)}, 32'h1);
      if (li >= 1) begin
         chk("stop_last_dibit", {30'h0, mon_q[li]}, 32'h1);
         chk("stop_prev_dibit", {30'h0, mon_q[li-1]}, 32'h3);
         chk("stop_idle_tail", {31'h0, ((mon_q.size() - 1 - li) >= 20)}, 32'h1);
      end
      do_frame("stop_status", 16'h4500);

      // Randomized write/read-back traffic against the model
      for (int n = 0; n < 25; n++) begin
         if ($urandom_range(0, 9) < 8) ra = 7'h20 + 7'($urandom_range(0, 7));
         else ra = 7'($urandom_range(0, 127));
         rdat = 8'($urandom_range(0, 255));
         do_frame($sformatf("rnd%0d_wr", n), {ra, 1'b0, rdat});
         do_frame($sformatf("rnd%0d_rd", n), {ra, 1'b1, 8'h00});
      end

      // Reset while transmitting forces reset values on the next clk
      do_frame("pre_rst_gpo", 16'h40A5);
      do_frame("pre_rst_pkt", 16'h4AB4);
      do_frame("pre_rst_en", 16'h4601);
      #200;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_lvds", {30'h0, to_lvds}, 32'h0);
      chk("midrst_gpo", {24'h0, gpo}, 32'h0);
      chk("midrst_led", {24'h0, led}, 32'h0);
      chk("midrst_miso", {31'h0, spi_bus.miso}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      m_reset();
      do_frame("post_rst_status", 16'h4500);
      do_frame("post_rst_dac", 16'h4700);
      chk("post_rst_lvds", {30'h0, to_lvds}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
